// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle control unit.
package ctrl_pkg;

  // One state per datapath phase; 4-bit encoding leaves room for growth.
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ILLEGAL = 4'd10
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Funct/ALUOp to ALUControl and flag-write enables.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic       i_alu_op,
  input  logic [5:0] i_funct,
  output logic [1:0] o_alu_control,
  output logic [1:0] o_flag_w
);

  // Command decode; unknown commands fall back to add, flags only when S=1.
  always_comb begin
    o_alu_control = ALU_ADD;
    o_flag_w      = 2'b00;
    if (i_alu_op) begin
      case (i_funct[4:1])
        4'b0100: o_alu_control = ALU_ADD;
        4'b0010: o_alu_control = ALU_SUB;
        4'b0000: o_alu_control = ALU_AND;
        4'b1100: o_alu_control = ALU_ORR;
        default: o_alu_control = ALU_ADD;
      endcase
      o_flag_w[1] = i_funct[0];
      o_flag_w[0] = i_funct[0] &
                    ((o_alu_control == ALU_ADD) || (o_alu_control == ALU_SUB));
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: one control word per execution phase.
//
// state     | meaning
// ----------+-------------------------------------------------
// FETCH     | read instr at PC, PC+4; waits for MemReady
// DECODE    | register read, PC+8 precompute
// MEMADR    | compute load/store address
// MEMRD     | data read request; waits for MemReady
// MEMWB     | write load data to register file
// MEMWR     | data write request; waits for MemReady
// EXECR     | ALU op, register operand
// EXECI     | ALU op, immediate operand
// ALUWB     | write ALU result to register file
// BRANCH    | branch target compute, Branch strobe
// ILLEGAL   | one-cycle Illegal pulse, then refetch
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       PCS,
  output logic       Illegal
);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_mem_req, w_ir_write, w_next_pc, w_adr_src, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_result_src;
  logic       w_alu_op, w_reg_w, w_mem_w, w_branch, w_illegal;
  logic [1:0] w_alu_control, w_flag_w;

  // State register; reset aborts any in-flight phase and restarts at fetch.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state logic; MemReady only matters in the memory-wait states.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (MemReady) w_next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  w_next_state = S_MEMADR;
          OP_DP:   w_next_state = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   w_next_state = S_BRANCH;
          default: w_next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: w_next_state = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) w_next_state = S_MEMWB;
      S_MEMWR:  if (MemReady) w_next_state = S_FETCH;
      S_EXECR,
      S_EXECI:  w_next_state = S_ALUWB;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // Moore control word; only IRWrite/NextPC look at MemReady directly.
  always_comb begin
    w_mem_req    = 1'b0;
    w_ir_write   = 1'b0;
    w_next_pc    = 1'b0;
    w_adr_src    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_result_src = 2'b00;
    w_alu_op     = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_branch     = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_ir_write   = MemReady;
        w_next_pc    = MemReady;
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
      end
      S_DECODE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
      end
      S_MEMADR: w_alu_src_b = 2'b01;
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_w      = 1'b1;
      end
      S_MEMWR: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        w_mem_w   = 1'b1;
      end
      S_EXECR: w_alu_op = 1'b1;
      S_EXECI: begin
        w_alu_src_b = 2'b01;
        w_alu_op    = 1'b1;
      end
      S_ALUWB: w_reg_w = 1'b1;
      S_BRANCH: begin
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_branch     = 1'b1;
      end
      S_ILLEGAL: w_illegal = 1'b1;
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct       (Funct),
    .o_alu_control (w_alu_control),
    .o_flag_w      (w_flag_w)
  );

  // Reset forces a quiet control word regardless of the registered state.
  assign MemReq     = ~reset & w_mem_req;
  assign IRWrite    = ~reset & w_ir_write;
  assign NextPC     = ~reset & w_next_pc;
  assign AdrSrc     = ~reset & w_adr_src;
  assign ALUSrcA    = ~reset & w_alu_src_a;
  assign ALUSrcB    = reset ? 2'b00 : w_alu_src_b;
  assign ResultSrc  = reset ? 2'b00 : w_result_src;
  assign ALUControl = reset ? 2'b00 : w_alu_control;
  assign FlagW      = reset ? 2'b00 : w_flag_w;
  assign RegW       = ~reset & w_reg_w;
  assign MemW       = ~reset & w_mem_w;
  assign Branch     = ~reset & w_branch;
  assign Illegal    = ~reset & w_illegal;
  assign PCS        = ~reset & (((Rd == 4'b1111) & w_reg_w) | w_branch);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [3:0] Rd = 4'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, IRWrite, NextPC, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
  logic       RegW, MemW, Branch, PCS, Illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [17:0] exp;
  } exp_t;
  exp_t sb[$];

  // Layout: MemReq IRWrite NextPC AdrSrc ALUSrcA ALUSrcB ResultSrc ALUControl FlagW RegW MemW Branch PCS Illegal
  localparam logic [17:0] E_ZERO   = 18'b0_0_0_0_0_00_00_00_00_0_0_0_0_0;
  localparam logic [17:0] E_FSTALL = 18'b1_0_0_0_1_10_10_00_00_0_0_0_0_0;
  localparam logic [17:0] E_FETCH  = 18'b1_1_1_0_1_10_10_00_00_0_0_0_0_0;
  localparam logic [17:0] E_DECODE = 18'b0_0_0_0_1_10_10_00_00_0_0_0_0_0;
  localparam logic [17:0] E_MEMADR = 18'b0_0_0_0_0_01_00_00_00_0_0_0_0_0;
  localparam logic [17:0] E_MEMRD  = 18'b1_0_0_1_0_00_00_00_00_0_0_0_0_0;
  localparam logic [17:0] E_MEMWB  = 18'b0_0_0_0_0_00_01_00_00_1_0_0_0_0;
  localparam logic [17:0] E_MEMWR  = 18'b1_0_0_1_0_00_00_00_00_0_1_0_0_0;
  localparam logic [17:0] E_ALUWB  = 18'b0_0_0_0_0_00_00_00_00_1_0_0_0_0;
  localparam logic [17:0] E_ALUWBP = 18'b0_0_0_0_0_00_00_00_00_1_0_0_1_0;
  localparam logic [17:0] E_BRANCH = 18'b0_0_0_0_0_01_10_00_00_0_0_1_1_0;
  localparam logic [17:0] E_ILL    = 18'b0_0_0_0_0_00_00_00_00_0_0_0_0_1;
  localparam logic [17:0] E_X_ADDS = 18'b0_0_0_0_0_00_00_00_11_0_0_0_0_0;
  localparam logic [17:0] E_X_SUBS = 18'b0_0_0_0_0_00_00_01_11_0_0_0_0_0;
  localparam logic [17:0] E_X_ANDS = 18'b0_0_0_0_0_00_00_10_10_0_0_0_0_0;
  localparam logic [17:0] E_X_UNKS = 18'b0_0_0_0_0_00_00_00_11_0_0_0_0_0;
  localparam logic [17:0] E_XI_ORR = 18'b0_0_0_0_0_01_00_11_00_0_0_0_0_0;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .MemReady   (MemReady),
    .MemReq     (MemReq),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .RegW       (RegW),
    .MemW       (MemW),
    .Branch     (Branch),
    .PCS        (PCS),
    .Illegal    (Illegal)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the expected word for this cycle goes to the scoreboard.
  task automatic cyc(input string name, input logic rst, input logic [1:0] op,
                     input logic [5:0] funct, input logic [3:0] rd,
                     input logic mr, input logic [17:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; Op = op; Funct = funct; Rd = rd; MemReady = mr;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Monitor: the control word is presented every cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [17:0] got;
      e = sb.pop_front();
      got = {MemReq, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
             ALUControl, FlagW, RegW, MemW, Branch, PCS, Illegal};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s got %b expected %b", e.name, got, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, MemReady high to show it is ignored under reset
    cyc("rst0", 1, 2'b00, 6'b001001, 4'd2, 1, E_ZERO);
    cyc("rst1", 1, 2'b00, 6'b001001, 4'd2, 1, E_ZERO);
    // ADD S=1, MemReady dropped in DECODE (ignored there)
    cyc("add_fetch",  0, 2'b00, 6'b001001, 4'd2, 1, E_FETCH);
    cyc("add_decode", 0, 2'b00, 6'b001001, 4'd2, 0, E_DECODE);
    cyc("add_execr",  0, 2'b00, 6'b001001, 4'd2, 1, E_X_ADDS);
    cyc("add_aluwb",  0, 2'b00, 6'b001001, 4'd2, 1, E_ALUWB);
    // LDR with two stall cycles in MEMRD: 7 cycles total
    cyc("ldr_fetch",  0, 2'b01, 6'b011001, 4'd3, 1, E_FETCH);
    cyc("ldr_decode", 0, 2'b01, 6'b011001, 4'd3, 1, E_DECODE);
    cyc("ldr_memadr", 0, 2'b01, 6'b011001, 4'd3, 1, E_MEMADR);
    cyc("ldr_memrd0", 0, 2'b01, 6'b011001, 4'd3, 0, E_MEMRD);
    cyc("ldr_memrd1", 0, 2'b01, 6'b011001, 4'd3, 0, E_MEMRD);
    cyc("ldr_memrd2", 0, 2'b01, 6'b011001, 4'd3, 1, E_MEMRD);
    cyc("ldr_memwb",  0, 2'b01, 6'b011001, 4'd3, 1, E_MEMWB);
    // STR with one FETCH stall and one MEMWR stall
    cyc("str_fstall", 0, 2'b01, 6'b011000, 4'd4, 0, E_FSTALL);
    cyc("str_fetch",  0, 2'b01, 6'b011000, 4'd4, 1, E_FETCH);
    cyc("str_decode", 0, 2'b01, 6'b011000, 4'd4, 1, E_DECODE);
    cyc("str_memadr", 0, 2'b01, 6'b011000, 4'd4, 1, E_MEMADR);
    cyc("str_memwr0", 0, 2'b01, 6'b011000, 4'd4, 0, E_MEMWR);
    cyc("str_memwr1", 0, 2'b01, 6'b011000, 4'd4, 1, E_MEMWR);
    // Branch: back in FETCH on the 4th cycle
    cyc("b_fetch",  0, 2'b10, 6'b100000, 4'd0, 1, E_FETCH);
    cyc("b_decode", 0, 2'b10, 6'b100000, 4'd0, 1, E_DECODE);
    cyc("b_branch", 0, 2'b10, 6'b100000, 4'd0, 1, E_BRANCH);
    // ORR immediate to R15 -> PCS in ALUWB
    cyc("orr_fetch",  0, 2'b00, 6'b111000, 4'd15, 1, E_FETCH);
    cyc("orr_decode", 0, 2'b00, 6'b111000, 4'd15, 1, E_DECODE);
    cyc("orr_execi",  0, 2'b00, 6'b111000, 4'd15, 1, E_XI_ORR);
    cyc("orr_aluwb",  0, 2'b00, 6'b111000, 4'd15, 1, E_ALUWBP);
    // SUBS, ANDS, unknown-cmd with S
    cyc("subs_fetch",  0, 2'b00, 6'b000101, 4'd1, 1, E_FETCH);
    cyc("subs_decode", 0, 2'b00, 6'b000101, 4'd1, 1, E_DECODE);
    cyc("subs_execr",  0, 2'b00, 6'b000101, 4'd1, 1, E_X_SUBS);
    cyc("subs_aluwb",  0, 2'b00, 6'b000101, 4'd1, 1, E_ALUWB);
    cyc("ands_fetch",  0, 2'b00, 6'b000001, 4'd1, 1, E_FETCH);
    cyc("ands_decode", 0, 2'b00, 6'b000001, 4'd1, 1, E_DECODE);
    cyc("ands_execr",  0, 2'b00, 6'b000001, 4'd1, 1, E_X_ANDS);
    cyc("ands_aluwb",  0, 2'b00, 6'b000001, 4'd1, 1, E_ALUWB);
    cyc("unk_fetch",   0, 2'b00, 6'b000011, 4'd1, 1, E_FETCH);
    cyc("unk_decode",  0, 2'b00, 6'b000011, 4'd1, 1, E_DECODE);
    cyc("unk_execr",   0, 2'b00, 6'b000011, 4'd1, 1, E_X_UNKS);
    cyc("unk_aluwb",   0, 2'b00, 6'b000011, 4'd1, 1, E_ALUWB);
    // Illegal op: one-cycle pulse, Rd=15 must not raise PCS
    cyc("ill_fetch",  0, 2'b11, 6'b000000, 4'd15, 1, E_FETCH);
    cyc("ill_decode", 0, 2'b11, 6'b000000, 4'd15, 1, E_DECODE);
    cyc("ill_pulse",  0, 2'b11, 6'b000000, 4'd15, 1, E_ILL);
    // Reset during a MEMWR stall; write is not reissued
    cyc("rstw_fetch",  0, 2'b01, 6'b011000, 4'd4, 1, E_FETCH);
    cyc("rstw_decode", 0, 2'b01, 6'b011000, 4'd4, 1, E_DECODE);
    cyc("rstw_memadr", 0, 2'b01, 6'b011000, 4'd4, 1, E_MEMADR);
    cyc("rstw_memwr",  0, 2'b01, 6'b011000, 4'd4, 0, E_MEMWR);
    cyc("rstw_abort",  1, 2'b01, 6'b011000, 4'd4, 0, E_ZERO);
    cyc("rstw_fstall", 0, 2'b01, 6'b011000, 4'd4, 0, E_FSTALL);
    cyc("rstw_fetch2", 0, 2'b01, 6'b011000, 4'd4, 1, E_FETCH);
    cyc("rstw_decode2",0, 2'b01, 6'b011000, 4'd4, 1, E_DECODE);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the multicycle ARM-subset core. It issues, one state per cycle, the control word for each phase of instruction execution (fetch, decode, address, memory, execute, write-back, branch) on the shared datapath: one ALU, one memory port, one register file. It decodes the same instruction fields as the single-cycle decoder and adds a memory-ready handshake, so fetches and data accesses may stall. It sits between the instruction register and the datapath muxes; condition checking stays in the separate condition unit, which gates RegW, MemW and PCS.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- Op  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- Funct  in  6  instr[25:20]: [5] I, [4:1] cmd, [0] S (data-processing) or L (memory).
- Rd  in  4  destination register.
- MemReady  in  1  memory has completed the current request this cycle.
- MemReq  out  1  memory access request.
- IRWrite  out  1  load instruction register.
- NextPC  out  1  PC ← PC+4.
- AdrSrc  out  1  0 = PC, 1 = ALU result.
- ALUSrcA  out  1  0 = Rn, 1 = PC.
- ALUSrcB  out  2  00 = Rm, 01 = extended immediate, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr.
- FlagW  out  2  [1] = NZ write enable, [0] = CV write enable.
- RegW, MemW, Branch  out  1 each  raw write enables and branch strobe.
- PCS  out  1  PC-source request.
- Illegal  out  1  one-cycle pulse when Op = 11 is decoded.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, ILLEGAL.
- Transitions:
  - FETCH → DECODE when MemReady; otherwise stay in FETCH.
  - DECODE → MEMADR when Op = 01.
  - DECODE → EXECI when Op = 00 and Funct[5] = 1.
  - DECODE → EXECR when Op = 00 and Funct[5] = 0.
  - DECODE → BRANCH when Op = 10.
  - DECODE → ILLEGAL when Op = 11.
  - MEMADR → MEMRD when Funct[0] = 1; → MEMWR when Funct[0] = 0.
  - MEMRD → MEMWB when MemReady; otherwise stay.
  - MEMWR → FETCH when MemReady; otherwise stay.
  - EXECR, EXECI → ALUWB.
  - MEMWB, ALUWB, BRANCH, ILLEGAL → FETCH.
- Control word per state (all signals not listed are 0):
  - FETCH: MemReq=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite and NextPC are 1 only in the cycle MemReady=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: MemReq=1, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: MemReq=1, AdrSrc=1, MemW=1, held for every cycle of the stall.
  - EXECR: ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - ILLEGAL: Illegal=1.
- ALU decode applies only when ALUOp=1. Funct[4:1] 0100 → 00, 0010 → 01, 0000 → 10, 1100 → 11; any other cmd → 00. FlagW[1]=Funct[0]; FlagW[0]=Funct[0] & (ALUControl is 00 or 01).
- When ALUOp=0: ALUControl=00 and FlagW=00.
- PCS = (Rd==1111 & RegW) | Branch.

## Timing
- Moore machine: outputs are decoded from the registered state. The only exceptions are IRWrite and NextPC, which are combinationally qualified by MemReady.
- Minimum instruction latency, with MemReady=1 on the first request cycle:
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Data-processing: 4 cycles.
  - Branch: 3 cycles.
  - Illegal: 3 cycles.
- Each cycle of MemReady=0 during FETCH, MEMRD or MEMWR adds exactly one cycle. No control output changes during a stall, except the qualified IRWrite and NextPC.
- MemReady outside FETCH, MEMRD and MEMWR is ignored.
- While reset=1, every output is 0 and MemReq=0, whatever the state. The state register loads FETCH at that edge. This holds for reset asserted mid-instruction, including during a MEMWR stall; the aborted write is not reissued.
- The first cycle after reset deasserts is FETCH, with MemReq=1.

## Structure
- Package ctrl_pkg holds:
  - the state enum (4-bit encoding);
  - ALUControl constants ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR;
  - Op constants OP_DP, OP_MEM, OP_BR.
- Sub-module alu_decoder is the combinational Funct/ALUOp → ALUControl/FlagW logic. It is instantiated once.
- The FSM keeps its next-state and output logic in one module alongside the state register.

## Test plan
- ADD with S=1 (Op=00, Funct=001001), MemReady always 1 → states FETCH, DECODE, EXECR, ALUWB. In EXECR: ALUControl=00, FlagW=11. In ALUWB: RegW=1.
- LDR (Op=01, Funct=011001) with MemReady=0 for 2 cycles in MEMRD → MEMRD lasts 3 cycles with AdrSrc=1, then MEMWB with ResultSrc=01 and RegW=1. Total 7 cycles.
- STR with MemReady low for 1 FETCH cycle → IRWrite and NextPC are 0 in the first FETCH cycle and 1 in the second. MemW=1 for every MEMWR cycle.
- Branch (Op=10) → BRANCH state with Branch=1 and PCS=1; back in FETCH on the 4th cycle. ORR to Rd=1111 → PCS=1 in ALUWB.
- Op=11 → Illegal pulses for exactly 1 cycle, then FETCH. All write enables stay 0 throughout.
- reset asserted during a MEMWR stall → MemW and MemReq are 0 in that cycle. The next cycle is FETCH with MemReq=1.
